// File: rtl/timer_countdown_core.sv
// Countdown engine: divides clk by a latched prescaler into ticks and
// counts a timer value down to zero, one step per tick.
module timer_countdown_core #(
  parameter int PRESCALER_WIDTH = 32,
  parameter int TIMER_WIDTH     = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PRESCALER_WIDTH-1:0] prescaler_value,
  input  logic [TIMER_WIDTH-1:0]     timer_value,
  input  logic                       start,
  input  logic                       stop,
  output logic [TIMER_WIDTH-1:0]     curr_timer,
  output logic                       ready,
  output logic                       expired
);

  typedef enum logic {
    IDLE    = 1'b0,
    RUNNING = 1'b1
  } state_t;

  localparam logic [PRESCALER_WIDTH-1:0] P_ONE  = PRESCALER_WIDTH'(1);
  localparam logic [TIMER_WIDTH-1:0]     T_ONE  = TIMER_WIDTH'(1);
  localparam logic [PRESCALER_WIDTH-1:0] P_ZERO = '0;
  localparam logic [TIMER_WIDTH-1:0]     T_ZERO = '0;

  state_t                     state_q, state_d;
  logic [PRESCALER_WIDTH-1:0] pctr_q, pctr_d;
  logic [PRESCALER_WIDTH-1:0] pval_q, pval_d;
  logic [TIMER_WIDTH-1:0]     curr_q, curr_d;
  logic                       expired_q, expired_d;

  logic [PRESCALER_WIDTH-1:0] pv_clamped;
  logic                       tick;

  // A prescaler of 0 behaves like 1 (one tick per clk).
  assign pv_clamped = (prescaler_value == P_ZERO) ? P_ONE : prescaler_value;
  assign tick       = (pctr_q <= P_ONE);

  always_comb begin
    state_d   = state_q;
    pctr_d    = pctr_q;
    pval_d    = pval_q;
    curr_d    = curr_q;
    expired_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          if (timer_value != T_ZERO) begin
            state_d = RUNNING;
            curr_d  = timer_value;
            pctr_d  = pv_clamped;
            pval_d  = pv_clamped;
          end else begin
            curr_d    = T_ZERO;
            expired_d = 1'b1;
          end
        end
      end
      RUNNING: begin
        // Stop beats a same-cycle tick: count freezes where it is.
        if (stop) begin
          state_d = IDLE;
          pctr_d  = P_ZERO;
        end else if (tick) begin
          pctr_d = pval_q;
          if (curr_q == T_ONE) begin
            curr_d    = T_ZERO;
            state_d   = IDLE;
            expired_d = 1'b1;
          end else begin
            curr_d = curr_q - T_ONE;
          end
        end else begin
          pctr_d = pctr_q - P_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pctr_q    <= '0;
      pval_q    <= '0;
      curr_q    <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pctr_q    <= pctr_d;
      pval_q    <= pval_d;
      curr_q    <= curr_d;
      expired_q <= expired_d;
    end
  end

  assign curr_timer = curr_q;
  assign ready      = (state_q == IDLE);
  assign expired    = expired_q;

endmodule

// File: tb/tb_timer_countdown_core.sv
// Directed bench for timer_countdown_core: hand-computed
// count, ready and expired values at each step.
module tb_timer_countdown_core;

  logic        clk;
  logic        reset;
  logic [31:0] prescaler_value;
  logic [31:0] timer_value;
  logic        start;
  logic        stop;
  logic [31:0] curr_timer;
  logic        ready;
  logic        expired;

  int n_cmp = 0;
  int n_err = 0;

  timer_countdown_core #(
    .PRESCALER_WIDTH(32),
    .TIMER_WIDTH(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .prescaler_value(prescaler_value),
    .timer_value(timer_value),
    .start(start),
    .stop(stop),
    .curr_timer(curr_timer),
    .ready(ready),
    .expired(expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [31:0] c,
                      input logic r, input logic e);
    chk({tag, ".curr"}, curr_timer, c);
    chk({tag, ".ready"}, {31'd0, ready}, {31'd0, r});
    chk({tag, ".expired"}, {31'd0, expired}, {31'd0, e});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic bad;
    reset = 1'b0;
    prescaler_value = 32'd1;
    timer_value = 32'd0;
    start = 1'b0;
    stop = 1'b0;

    // 1: async reset with no clock edge
    #1 reset = 1'b1;
    #1 chk3("t1_reset", 32'd0, 1'b1, 1'b0);
    reset = 1'b0;

    // 2: P=1, T=3
    prescaler_value = 32'd1;
    timer_value = 32'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    chk3("t2_e0", 32'd3, 1'b0, 1'b0);
    step(); chk3("t2_e1", 32'd2, 1'b0, 1'b0);
    step(); chk3("t2_e2", 32'd1, 1'b0, 1'b0);
    step(); chk3("t2_e3", 32'd0, 1'b1, 1'b1);
    step(); chk3("t2_e4", 32'd0, 1'b1, 1'b0);

    // 3: P=4, T=2 -> 8 cycles
    prescaler_value = 32'd4;
    timer_value = 32'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    chk3("t3_e0", 32'd2, 1'b0, 1'b0);
    for (int i = 1; i < 8; i++) begin
      step();
      chk3($sformatf("t3_e%0d", i), (i < 4) ? 32'd2 : 32'd1, 1'b0, 1'b0);
    end
    step(); chk3("t3_e8", 32'd0, 1'b1, 1'b1);

    // 3b: P=0 behaves as P=1
    prescaler_value = 32'd0;
    timer_value = 32'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    chk3("t3b_e0", 32'd2, 1'b0, 1'b0);
    step(); chk3("t3b_e1", 32'd1, 1'b0, 1'b0);
    step(); chk3("t3b_e2", 32'd0, 1'b1, 1'b1);

    // 4: P=2, T=100, stop sampled at E11 -> frozen at 95
    prescaler_value = 32'd2;
    timer_value = 32'd100;
    start = 1'b1;
    step();
    start = 1'b0;
    chk3("t4_e0", 32'd100, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) step();
    chk3("t4_e10", 32'd95, 1'b0, 1'b0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk3("t4_stop", 32'd95, 1'b1, 1'b0);
    step(); chk3("t4_hold1", 32'd95, 1'b1, 1'b0);
    step(); chk3("t4_hold2", 32'd95, 1'b1, 1'b0);

    // 5: T=0 start from a frozen count
    timer_value = 32'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk3("t5_zero", 32'd0, 1'b1, 1'b1);
    step(); chk3("t5_after", 32'd0, 1'b1, 1'b0);

    // 5b: start+stop together in IDLE
    timer_value = 32'd50;
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    chk3("t5_both", 32'd0, 1'b1, 1'b0);
    step(); chk3("t5_both2", 32'd0, 1'b1, 1'b0);

    // 4b: restart reloads 100, completes after 200 cycles
    prescaler_value = 32'd2;
    timer_value = 32'd100;
    start = 1'b1;
    step();
    start = 1'b0;
    chk3("t4b_e0", 32'd100, 1'b0, 1'b0);
    bad = 1'b0;
    for (int i = 1; i < 200; i++) begin
      step();
      if (ready !== 1'b0 || expired !== 1'b0 ||
          curr_timer !== 32'(100 - i / 2))
        bad = 1'b1;
    end
    chk("t4b_run_clean", {31'd0, bad}, 32'd0);
    step(); chk3("t4b_e200", 32'd0, 1'b1, 1'b1);

    // 6: input changes and start during RUNNING are ignored
    prescaler_value = 32'd3;
    timer_value = 32'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    chk3("t6_e0", 32'd5, 1'b0, 1'b0);
    prescaler_value = 32'd1;
    timer_value = 32'd9;
    start = 1'b1;
    step();
    start = 1'b0;
    chk3("t6_e1", 32'd5, 1'b0, 1'b0);
    step(); chk3("t6_e2", 32'd5, 1'b0, 1'b0);
    step(); chk3("t6_e3", 32'd4, 1'b0, 1'b0);
    for (int i = 4; i <= 14; i++) step();
    chk3("t6_e14", 32'd1, 1'b0, 1'b0);
    step(); chk3("t6_e15", 32'd0, 1'b1, 1'b1);

    // 6b: async reset mid-run at count 37
    prescaler_value = 32'd1;
    timer_value = 32'd40;
    start = 1'b1;
    step();
    start = 1'b0;
    chk3("t6b_e0", 32'd40, 1'b0, 1'b0);
    step(); step(); step();
    chk3("t6b_e3", 32'd37, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1 chk3("t6b_reset", 32'd0, 1'b1, 1'b0);
    reset = 1'b0;
    step(); chk3("t6b_post", 32'd0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
